lcd_show_text: RTL and testbench

LCD_SHOW_TEXT -- requirements
Module: lcd_show_text

---
 rtl/lcd_show_text.sv | 254 +++++++++++++++++++++++++
 tb/tb_lcd_show_text.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_show_text.sv
`default_nettype none
// ============================================================================
// Module   : lcd_show_text
// Brief    : Renders an ASCII string onto an LCD panel through a byte-wide
//            SPI write path, fetching glyph rows from an external font ROM.
//            Optional macro LCD_TEXT_HILITE_EN enables per-character highlight.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_show_text #(
    parameter int unsigned FONT_W    = 6,
    parameter int unsigned FONT_H    = 12,
    parameter int unsigned MAX_CHARS = 16,
    parameter int unsigned ROM_BASE  = 0,
    parameter int unsigned ROM_LAT   = 1,
    parameter logic [8:0]  X_OFS     = 9'h28,
    parameter logic [8:0]  Y_OFS     = 9'h35,
    localparam int unsigned c_LEN_W  = $clog2(MAX_CHARS + 1),
    localparam int unsigned c_CHR_W  = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   start,
    input  logic [MAX_CHARS*8-1:0] str_data,
    input  logic [c_LEN_W-1:0]     str_len,
    input  logic [8:0]             start_x,
    input  logic [8:0]             start_y,
    input  logic [15:0]            fg_color,
    input  logic [15:0]            bg_color,
    input  logic [c_CHR_W-1:0]     hilite_idx,
    input  logic [15:0]            hilite_color,
    output logic [11:0]            rom_addr,
    input  logic [7:0]             rom_q,
    input  logic                   wr_done,
    output logic [8:0]             lcd_data,
    output logic                   en_write,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned c_ROW_W = (FONT_H > 1) ? $clog2(FONT_H) : 1;
    localparam int unsigned c_LAT_W = $clog2(ROM_LAT + 2);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WIN   = 3'd1,
        FETCH = 3'd2,
        PIX   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [MAX_CHARS*8-1:0] r_str;
    logic [c_LEN_W-1:0]     r_len;
    logic [8:0]             r_xs, r_xe, r_ys, r_ye;
    logic [15:0]            r_fg, r_bg;
    logic [3:0]             r_widx;
    logic [c_ROW_W-1:0]     r_row;
    logic [c_CHR_W-1:0]     r_chr;
    logic [2:0]             r_col;
    logic                   r_lo;
    logic                   r_pend;
    logic [c_LAT_W-1:0]     r_lat;
    logic [7:0]             r_glyph;

    logic [c_LEN_W-1:0] w_len;
    logic [8:0]         w_xs, w_xe, w_ys, w_ye;
    logic [8:0]         w_win_byte, w_pix_byte, w_byte;
    logic [7:0]         w_char, w_gidx;
    logic [11:0]        w_addr;
    logic [15:0]        w_fg, w_color;
    logic               w_issue, w_accept, w_ack;
    logic               w_last_col, w_last_chr, w_last_row, w_lat_done;

    assign w_len = (32'(str_len) > MAX_CHARS) ? c_LEN_W'(MAX_CHARS) : str_len;
    assign w_xs  = start_x + X_OFS;
    assign w_ys  = start_y + Y_OFS;
    assign w_xe  = w_xs + 9'(32'(w_len) * FONT_W) - 9'd1;
    assign w_ye  = w_ys + 9'(FONT_H - 1);

    always_comb begin
        w_win_byte = 9'h000;
        case (r_widx)
            4'd0:    w_win_byte = 9'h02A;
            4'd1:    w_win_byte = {8'h80, r_xs[8]};
            4'd2:    w_win_byte = {1'b1, r_xs[7:0]};
            4'd3:    w_win_byte = {8'h80, r_xe[8]};
            4'd4:    w_win_byte = {1'b1, r_xe[7:0]};
            4'd5:    w_win_byte = 9'h02B;
            4'd6:    w_win_byte = {8'h80, r_ys[8]};
            4'd7:    w_win_byte = {1'b1, r_ys[7:0]};
            4'd8:    w_win_byte = {8'h80, r_ye[8]};
            4'd9:    w_win_byte = {1'b1, r_ye[7:0]};
            default: w_win_byte = 9'h02C;
        endcase
    end

    // Non-printable codes fall back to the space glyph at index 0
    assign w_char = r_str[32'(r_chr)*8 +: 8];
    assign w_gidx = (w_char >= 8'h20 && w_char <= 8'h7E) ? (w_char - 8'h20) : 8'h00;
    assign w_addr = 12'(ROM_BASE + 32'(w_gidx) * FONT_H + 32'(r_row));

    assign w_last_col = (32'(r_col) == FONT_W - 1);
    assign w_last_chr = (32'(r_chr) == 32'(r_len) - 1);
    assign w_last_row = (32'(r_row) == FONT_H - 1);
    assign w_lat_done = (32'(r_lat) == ROM_LAT + 1);

`ifdef LCD_TEXT_HILITE_EN
    logic [c_CHR_W-1:0] r_hidx;
    logic [15:0]        r_hcol;
    logic               r_hi_en;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_hidx  <= '0;
            r_hcol  <= '0;
            r_hi_en <= 1'b0;
        end else if (w_accept) begin
            r_hidx  <= hilite_idx;
            r_hcol  <= hilite_color;
            r_hi_en <= (32'(hilite_idx) < 32'(w_len));
        end
    end

    assign w_fg = (r_hi_en && (r_chr == r_hidx)) ? r_hcol : r_fg;
`else
    logic w_unused_hilite;
    assign w_unused_hilite = ^{hilite_idx, hilite_color};
    assign w_fg            = r_fg;
`endif

    assign w_color    = r_glyph[r_col] ? w_fg : r_bg;
    assign w_pix_byte = {1'b1, r_lo ? w_color[7:0] : w_color[15:8]};
    assign w_ack      = r_pend && wr_done;

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_accept    = 1'b0;
        w_byte      = w_win_byte;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (w_len == '0) ? DONE : WIN;
                end
            end
            WIN: begin
                if (!r_pend) begin
                    w_issue = 1'b1;
                end else if (wr_done && (r_widx == 4'd10)) begin
                    w_state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (w_lat_done) begin
                    w_state_nxt = PIX;
                end
            end
            PIX: begin
                w_byte = w_pix_byte;
                if (!r_pend) begin
                    w_issue = 1'b1;
                end else if (wr_done && r_lo && w_last_col) begin
                    w_state_nxt = (w_last_chr && w_last_row) ? DONE : FETCH;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_str <= '0;  r_len <= '0;
            r_xs  <= '0;  r_xe  <= '0;  r_ys <= '0;  r_ye <= '0;
            r_fg  <= '0;  r_bg  <= '0;
            r_widx <= '0; r_row <= '0;  r_chr <= '0; r_col <= '0;
            r_lo  <= 1'b0; r_pend <= 1'b0; r_lat <= '0; r_glyph <= '0;
            lcd_data <= '0; rom_addr <= '0; en_write <= 1'b0;
        end else begin
            en_write <= w_issue;
            if (w_issue) begin
                lcd_data <= w_byte;
                r_pend   <= 1'b1;
            end
            if (w_ack) begin
                r_pend <= 1'b0;
            end
            if (w_accept) begin
                r_str <= str_data;  r_len <= w_len;
                r_xs  <= w_xs;      r_xe  <= w_xe;
                r_ys  <= w_ys;      r_ye  <= w_ye;
                r_fg  <= fg_color;  r_bg  <= bg_color;
                r_widx <= '0; r_row <= '0; r_chr <= '0; r_col <= '0;
                r_lo  <= 1'b0; r_lat <= '0;
            end
            case (r_state)
                WIN: begin
                    if (w_ack) begin
                        r_widx <= (r_widx == 4'd10) ? 4'd0 : r_widx + 4'd1;
                    end
                end
                FETCH: begin
                    if (r_lat == '0) begin
                        rom_addr <= w_addr;
                    end
                    // Address is held one cycle, then ROM_LAT cycles of ROM latency
                    if (w_lat_done) begin
                        r_glyph <= rom_q;
                        r_lat   <= '0;
                        r_col   <= '0;
                        r_lo    <= 1'b0;
                    end else begin
                        r_lat <= r_lat + 1'b1;
                    end
                end
                PIX: begin
                    if (w_ack) begin
                        r_lo <= ~r_lo;
                        if (r_lo) begin
                            if (!w_last_col) begin
                                r_col <= r_col + 3'd1;
                            end else begin
                                r_col <= '0;
                                if (!w_last_chr) begin
                                    r_chr <= r_chr + 1'b1;
                                end else begin
                                    r_chr <= '0;
                                    if (!w_last_row) begin
                                        r_row <= r_row + 1'b1;
                                    end
                                end
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != IDLE);
    assign done = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_lcd_show_text.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_show_text
// Brief    : Directed self-checking bench for lcd_show_text (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_show_text;

    logic         sys_clk = 1'b0;
    logic         sys_rst = 1'b1;
    logic         start   = 1'b0;
    logic [127:0] str_data = '0;
    logic [4:0]   str_len  = '0;
    logic [8:0]   start_x  = '0;
    logic [8:0]   start_y  = '0;
    logic [15:0]  fg_color = '0;
    logic [15:0]  bg_color = '0;
    logic [3:0]   hilite_idx   = '0;
    logic [15:0]  hilite_color = '0;
    logic [11:0]  rom_addr;
    logic [7:0]   rom_q = '0;
    logic         wr_done;
    logic [8:0]   lcd_data;
    logic         en_write, busy, done;

    lcd_show_text dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start),
        .str_data(str_data), .str_len(str_len),
        .start_x(start_x), .start_y(start_y),
        .fg_color(fg_color), .bg_color(bg_color),
        .hilite_idx(hilite_idx), .hilite_color(hilite_color),
        .rom_addr(rom_addr), .rom_q(rom_q), .wr_done(wr_done),
        .lcd_data(lcd_data), .en_write(en_write), .busy(busy), .done(done)
    );

    always #5 sys_clk = ~sys_clk;

    // Font ROM model: space glyph (0..11) is blank, everything else patterned
    function automatic logic [7:0] rom_fn(input logic [11:0] a);
        return (a < 12'd12) ? 8'h00 : 8'(a * 37 + 5);
    endfunction

    always @(posedge sys_clk) rom_q <= rom_fn(rom_addr);

    // SPI responder: wr_done three cycles after each en_write
    int   wd_cnt   = 0;
    logic wd_resp  = 1'b0;
    logic wd_extra = 1'b0;
    assign wr_done = wd_resp | wd_extra;

    always @(negedge sys_clk) begin
        wd_resp = 1'b0;
        if (sys_rst) begin
            wd_cnt = 0;
        end else if (en_write) begin
            wd_cnt = 3;
        end else if (wd_cnt > 0) begin
            wd_cnt--;
            if (wd_cnt == 0) wd_resp = 1'b1;
        end
    end

    logic [8:0]  got_q[$];
    logic [11:0] rom_log[$];
    logic [11:0] prev_addr = '0;
    int          done_cnt  = 0;
    int          overlap   = 0;

    always @(negedge sys_clk) begin
        if (en_write) got_q.push_back(lcd_data);
        if (done) done_cnt++;
        if (done && en_write) overlap++;
        if (rom_addr != prev_addr) begin
            rom_log.push_back(rom_addr);
            prev_addr = rom_addr;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [8:0] exp_q[$];

    task automatic build_exp(input logic [127:0] s, input int len, input logic [8:0] x,
                             input logic [8:0] y, input logic [15:0] fg, input logic [15:0] bg,
                             input int hidx, input logic [15:0] hcol);
        int L;
        logic [8:0] xs, ys, xe, ye;
        logic [7:0] ch, g, row;
        logic [15:0] col;
        logic hl;
`ifdef LCD_TEXT_HILITE_EN
        hl = 1'b1;
`else
        hl = 1'b0;
`endif
        L = (len > 16) ? 16 : len;
        exp_q.delete();
        if (L == 0) return;
        xs = x + 9'h28;
        ys = y + 9'h35;
        xe = 9'(32'(xs) + 32'(L) * 6 - 1);
        ye = 9'(32'(ys) + 11);
        exp_q.push_back(9'h02A); exp_q.push_back({8'h80, xs[8]}); exp_q.push_back({1'b1, xs[7:0]});
        exp_q.push_back({8'h80, xe[8]}); exp_q.push_back({1'b1, xe[7:0]});
        exp_q.push_back(9'h02B); exp_q.push_back({8'h80, ys[8]}); exp_q.push_back({1'b1, ys[7:0]});
        exp_q.push_back({8'h80, ye[8]}); exp_q.push_back({1'b1, ye[7:0]});
        exp_q.push_back(9'h02C);
        for (int r = 0; r < 12; r++) begin
            for (int c = 0; c < L; c++) begin
                ch  = s[8*c +: 8];
                g   = (ch >= 8'h20 && ch <= 8'h7E) ? ch - 8'h20 : 8'h00;
                row = rom_fn(12'(32'(g) * 12 + r));
                for (int k = 0; k < 6; k++) begin
                    col = row[k] ? ((hl && c == hidx) ? hcol : fg) : bg;
                    exp_q.push_back({1'b1, col[15:8]});
                    exp_q.push_back({1'b1, col[7:0]});
                end
            end
        end
    endtask

    task automatic compare_stream(input string tag, input int base);
        int n;
        int e0;
        n = got_q.size() - base;
        check({tag, "_count"}, 32'(n), 32'(exp_q.size()));
        if (n > exp_q.size()) n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            e0 = errors;
            check({tag, "_byte"}, 32'(got_q[base + i]), 32'(exp_q[i]));
            if (errors != e0) break;
        end
    endtask

    task automatic do_start(input logic [127:0] s, input logic [4:0] len, input logic [8:0] x,
                            input logic [8:0] y, input logic [15:0] fg, input logic [15:0] bg,
                            input logic [3:0] hidx, input logic [15:0] hcol);
        @(negedge sys_clk);
        str_data = s; str_len = len; start_x = x; start_y = y;
        fg_color = fg; bg_color = bg; hilite_idx = hidx; hilite_color = hcol;
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 8000) begin
            @(negedge sys_clk);
            n++;
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        repeat (3) @(negedge sys_clk);
    endtask

    function automatic int count_hilite_pairs(input int base);
        int cnt = 0;
        for (int i = base + 11; i + 1 < got_q.size(); i += 2)
            if (got_q[i] == 9'h1F8 && got_q[i+1] == 9'h100) cnt++;
        return cnt;
    endfunction

    logic [8:0] win_ref [11];
    int b0, r0, d0, n, hl_exp;
    logic [7:0] grow;

    initial begin
        win_ref = '{9'h02A, 9'h100, 9'h128, 9'h100, 9'h12D, 9'h02B,
                    9'h100, 9'h135, 9'h100, 9'h140, 9'h02C};

        repeat (3) @(negedge sys_clk);
        check("rst_lcd_data", 32'(lcd_data), 0);
        check("rst_rom_addr", 32'(rom_addr), 0);
        check("rst_en_write", 32'(en_write), 0);
        check("rst_busy",     32'(busy), 0);
        check("rst_done",     32'(done), 0);
        sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);

        // Single character "A" at (0,0)
        b0 = got_q.size(); r0 = rom_log.size(); d0 = done_cnt;
        do_start(128'h41, 5'd1, 9'd0, 9'd0, 16'hFFFF, 16'h0000, 4'd0, 16'h0000);
        check("a_busy", 32'(busy), 1);
        wait_done("a");
        check("a_en_count", 32'(got_q.size() - b0), 155);
        for (int i = 0; i < 11; i++)
            if (b0 + i < got_q.size()) check("a_win", 32'(got_q[b0 + i]), 32'(win_ref[i]));
        check("a_rom_count", 32'(rom_log.size() - r0), 12);
        for (int i = 0; i < 12; i++)
            if (r0 + i < rom_log.size()) check("a_rom_addr", 32'(rom_log[r0 + i]), 32'(396 + i));
        check("a_done_cnt", 32'(done_cnt - d0), 1);
        build_exp(128'h41, 1, 9'd0, 9'd0, 16'hFFFF, 16'h0000, 0, 16'h0000);
        compare_stream("a_stream", b0);

        // Zero length: done right after start, no bytes
        b0 = got_q.size(); d0 = done_cnt;
        do_start(128'h41, 5'd0, 9'd0, 9'd0, 16'hFFFF, 16'h0000, 4'd0, 16'h0000);
        check("len0_done_next", 32'(done), 1);
        repeat (10) @(negedge sys_clk);
        check("len0_no_write", 32'(got_q.size() - b0), 0);
        check("len0_done_cnt", 32'(done_cnt - d0), 1);

        // Control character maps to blank space glyph
        b0 = got_q.size(); r0 = rom_log.size();
        do_start(128'h0A, 5'd1, 9'd0, 9'd0, 16'hFFFF, 16'h1536, 4'd0, 16'h0000);
        wait_done("ctl");
        check("ctl_en_count", 32'(got_q.size() - b0), 155);
        check("ctl_rom_count", 32'(rom_log.size() - r0), 12);
        for (int i = 0; i < 12; i++)
            if (r0 + i < rom_log.size()) check("ctl_rom_addr", 32'(rom_log[r0 + i]), 32'(i));
        n = 0;
        for (int i = 11; i < 155 && b0 + i < got_q.size(); i++)
            if (got_q[b0 + i] != ((i % 2 == 1) ? 9'h115 : 9'h136)) n++;
        check("ctl_bg_bytes", 32'(n), 0);

        // Reset mid-string aborts, then a restart completes normally
        b0 = got_q.size(); d0 = done_cnt;
        do_start(128'h5958, 5'd2, 9'd3, 9'd4, 16'hABCD, 16'h1234, 4'd0, 16'h0000);
        n = 0;
        while (got_q.size() - b0 < 40 && n < 2000) begin
            @(negedge sys_clk);
            n++;
        end
        check("abort_reached40", 32'(got_q.size() - b0 >= 40), 1);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check("abort_lcd_data", 32'(lcd_data), 0);
        check("abort_rom_addr", 32'(rom_addr), 0);
        check("abort_en_write", 32'(en_write), 0);
        check("abort_busy",     32'(busy), 0);
        check("abort_done",     32'(done), 0);
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (5) @(negedge sys_clk);
        check("abort_no_done", 32'(done_cnt - d0), 0);
        b0 = got_q.size();
        do_start(128'h5958, 5'd2, 9'd3, 9'd4, 16'hABCD, 16'h1234, 4'd0, 16'h0000);
        wait_done("restart");
        build_exp(128'h5958, 2, 9'd3, 9'd4, 16'hABCD, 16'h1234, 0, 16'h0000);
        compare_stream("restart_stream", b0);

        // Start while busy is ignored
        b0 = got_q.size(); d0 = done_cnt;
        do_start(128'h216948, 5'd3, 9'd100, 9'd200, 16'h5A5A, 16'h0F0F, 4'd0, 16'h0000);
        repeat (300) @(negedge sys_clk);
        check("busy_mid", 32'(busy), 1);
        str_len = 5'd1; start_x = 9'd0; fg_color = 16'h0000;
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        wait_done("busy");
        check("busy_done_cnt", 32'(done_cnt - d0), 1);
        build_exp(128'h216948, 3, 9'd100, 9'd200, 16'h5A5A, 16'h0F0F, 0, 16'h0000);
        compare_stream("busy_stream", b0);

        // Stray wr_done pulses while idle
        b0 = got_q.size();
        repeat (3) begin
            @(negedge sys_clk); wd_extra = 1'b1;
            @(negedge sys_clk); wd_extra = 1'b0;
        end
        repeat (5) @(negedge sys_clk);
        check("idle_wrdone_no_write", 32'(got_q.size() - b0), 0);
        check("idle_wrdone_busy", 32'(busy), 0);

        // Highlight on character 1 ("ABC")
        hl_exp = 0;
`ifdef LCD_TEXT_HILITE_EN
        for (int r = 0; r < 12; r++) begin
            grow = rom_fn(12'(34 * 12 + r));
            for (int k = 0; k < 6; k++) hl_exp += grow[k];
        end
`endif
        b0 = got_q.size();
        do_start(128'h434241, 5'd3, 9'd0, 9'd0, 16'h07E0, 16'h001F, 4'd1, 16'hF800);
        wait_done("hl1");
        build_exp(128'h434241, 3, 9'd0, 9'd0, 16'h07E0, 16'h001F, 1, 16'hF800);
        compare_stream("hl1_stream", b0);
        check("hl1_pairs", 32'(count_hilite_pairs(b0)), 32'(hl_exp));

        b0 = got_q.size();
        do_start(128'h434241, 5'd3, 9'd0, 9'd0, 16'h07E0, 16'h001F, 4'd5, 16'hF800);
        wait_done("hl5");
        build_exp(128'h434241, 3, 9'd0, 9'd0, 16'h07E0, 16'h001F, 5, 16'hF800);
        compare_stream("hl5_stream", b0);
        check("hl5_pairs", 32'(count_hilite_pairs(b0)), 0);

        check("done_en_overlap", 32'(overlap), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
